decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the datapath width for PC, immediate and target.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, the stall-counter width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid_i, input, 1, fetch offers an instruction.
REQ-006 SHALL have port in_ready_o, output, 1, stage can accept an instruction this cycle.
REQ-007 SHALL have port in_inst_i, input, 32, raw instruction word.
REQ-008 SHALL have port in_pc_i, input, DATA_WIDTH, PC of in_inst_i.
REQ-009 SHALL have port flush_i, input, 1, discard all held and incoming instructions.
REQ-010 SHALL have port out_valid_o, output, 1, decoded instruction available.
REQ-011 SHALL have port out_ready_i, input, 1, execute accepts the decoded instruction.
REQ-012 SHALL have ports out_pc_o / out_inst_o / out_imm_o / out_target_o, output, DATA_WIDTH/32/DATA_WIDTH/DATA_WIDTH, decoded head entry.
REQ-013 SHALL have ports out_rd_o / out_rs1_o / out_rs2_o, output, 5 each, register indices inst[11:7]/[19:15]/[24:20].
REQ-014 SHALL have port out_illegal_o, output, 1, head opcode unsupported.
REQ-015 SHALL have port stall_cnt_o, output, CNT_WIDTH, back-pressure cycle count.

Function
REQ-016 SHALL buffer up to 2 decoded entries in order (states EMPTY, ONE, FULL).
REQ-017 SHALL drive in_ready_o = 1 when state is not FULL, combinationally independent of out_ready_i.
REQ-018 SHALL accept on in_valid_i && in_ready_o && !flush_i; SHALL pop on out_valid_o && out_ready_i.
REQ-019 SHALL transition EMPTY->ONE on accept; ONE->FULL on accept without pop; ONE->EMPTY on pop without accept; FULL->ONE on pop; simultaneous accept+pop SHALL keep state.
REQ-020 SHALL present an accepted instruction at the outputs the cycle after acceptance (latency 1) when the buffer was empty.
REQ-021 SHALL decode the immediate at accept time and store it: I-type (0x13, 0x1b, 0x03, 0x67) sext(inst[31:20]); S (0x23) sext({inst[31:25],inst[11:7]}); B (0x63) sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); J (0x6f) sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); U (0x17, 0x37) sext({inst[31:12],12'b0}) to DATA_WIDTH.
REQ-022 SHALL compute out_target_o = pc + imm (modulo 2^DATA_WIDTH) for opcodes 0x63, 0x6f, 0x17; 0 otherwise.
REQ-023 SHALL flag illegal for any opcode outside {0x13,0x1b,0x03,0x23,0x63,0x67,0x6f,0x17,0x37,0x33,0x3b,0x73}; illegal entries carry imm=0, target=0 and are still passed downstream.
REQ-024 SHALL hold all out_* stable while out_valid_o && !out_ready_i.
REQ-025 flush_i SHALL empty the buffer at the next edge, override any same-cycle accept and pop, and leave stall_cnt_o unchanged.
REQ-026 SHALL increment stall_cnt_o each cycle out_valid_o && !out_ready_i && !flush_i, saturating at all-ones.
REQ-027 SHALL drive out_* data to 0 when out_valid_o = 0.

Reset
REQ-028 Asserting rst_ni low SHALL immediately force state EMPTY, out_valid_o=0, in_ready_o=1, all out_* data 0, stall_cnt_o=0, mid-transfer entries discarded.
REQ-029 After rst_ni deasserts, the first accept SHALL be possible in the first clock cycle.

Structure
REQ-030 Opcode constants and an entry struct (pc, inst, imm, target, illegal) SHALL live in the shared package riscv_pkg.
REQ-031 The 2-entry ordered store with count/pointers SHALL be a sub-module decode_fifo2; decode and counter logic stay in decode_stage.

Verification
REQ-032 addi x1,x0,-1 (0xFFF00093), pc 0x8000_0000 -> next cycle out_valid_o=1, imm 0xFFFF_FFFF_FFFF_FFFF, rd=1, rs1=0, illegal=0.
REQ-033 beq x0,x0,-4 (0xFE000EE3), pc 0x8000_0010 -> imm 0xFFFF_FFFF_FFFF_FFFC, target 0x8000_000C.
REQ-034 lui x5,0x80000 (0x800002B7) -> imm 0xFFFF_FFFF_8000_0000, rd=5; inst 0x0000007F -> illegal=1, imm=0.
REQ-035 out_ready_i=0, three back-to-back offers -> 2 accepted, in_ready_o=0 on third, stall_cnt_o increments per cycle, outputs stable; release -> in-order drain.
REQ-036 FULL buffer plus flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, offered instruction dropped.
REQ-037 rst_ni low mid-stream while FULL -> outputs 0 immediately without a clock edge; CNT_WIDTH=4 with 20 stall cycles -> stall_cnt_o saturates at 0xF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 decode definitions: opcode constants, the buffered entry layout
// and the immediate/target helpers used by the decode stage.
package riscv_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM_32 = 7'h1b;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_OP_32  = 7'h3b;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;

  // Fields are sized for the widest datapath; narrower stages zero-fill the top.
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         inst;
    logic [XLEN_MAX-1:0] imm;
    logic [XLEN_MAX-1:0] target;
    logic                illegal;
  } entry_t;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_IMM, OP_IMM_32, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR,
      OP_JAL, OP_AUIPC, OP_LUI, OP_OP, OP_OP_32, OP_SYSTEM: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic has_target(input logic [6:0] op);
    has_target = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_AUIPC);
  endfunction

  function automatic logic [XLEN_MAX-1:0] decode_imm(input logic [31:0] inst);
    case (inst[6:0])
      OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR:
        decode_imm = {{52{inst[31]}}, inst[31:20]};
      OP_STORE:
        decode_imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        decode_imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_JAL:
        decode_imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_AUIPC, OP_LUI:
        decode_imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      default:
        decode_imm = '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_fifo2.sv
// Two-entry in-order store; the state doubles as the occupancy count and
// flush empties it without touching the stored words.
module decode_fifo2
  import riscv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             ready,
  output logic [WIDTH-1:0] head
);

  fifo_state_t      state;
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (state != FULL);
  assign do_pop  = pop && (state != EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case (state)
        EMPTY: if (do_push) state <= ONE;
        ONE: begin
          if (do_push && !do_pop)      state <= FULL;
          else if (do_pop && !do_push) state <= EMPTY;
        end
        FULL:    if (do_pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  assign valid = (state != EMPTY);
  assign ready = (state != FULL);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes immediate/target at accept time, buffers up to two
// entries and counts cycles lost to downstream back-pressure.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           in_inst_i,
  input  logic [DATA_WIDTH-1:0] in_pc_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_pc_o,
  output logic [31:0]           out_inst_o,
  output logic [DATA_WIDTH-1:0] out_imm_o,
  output logic [DATA_WIDTH-1:0] out_target_o,
  output logic [4:0]            out_rd_o,
  output logic [4:0]            out_rs1_o,
  output logic [4:0]            out_rs2_o,
  output logic                  out_illegal_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  logic [6:0]            opcode;
  logic [XLEN_MAX-1:0]   imm_full;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] target;
  logic                  illegal;
  entry_t                in_entry;
  entry_t                head;
  logic                  push;
  logic                  pop;

  assign opcode   = in_inst_i[6:0];
  assign imm_full = decode_imm(in_inst_i);

  // Illegal opcodes fall to the zero default of decode_imm, so imm is 0 for them.
  always_comb begin
    in_entry = '0;
    illegal  = !is_legal(opcode);
    imm      = imm_full[DATA_WIDTH-1:0];
    target   = has_target(opcode) ? (in_pc_i + imm) : '0;
    in_entry.pc[DATA_WIDTH-1:0]     = in_pc_i;
    in_entry.inst                   = in_inst_i;
    in_entry.imm[DATA_WIDTH-1:0]    = imm;
    in_entry.target[DATA_WIDTH-1:0] = target;
    in_entry.illegal                = illegal;
  end

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i;

  decode_fifo2 #(
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .flush    (flush_i),
    .push     (push),
    .push_data(in_entry),
    .pop      (pop),
    .valid    (out_valid_o),
    .ready    (in_ready_o),
    .head     (head)
  );

  always_comb begin
    out_pc_o      = '0;
    out_inst_o    = '0;
    out_imm_o     = '0;
    out_target_o  = '0;
    out_rd_o      = '0;
    out_rs1_o     = '0;
    out_rs2_o     = '0;
    out_illegal_o = 1'b0;
    if (out_valid_o) begin
      out_pc_o      = head.pc[DATA_WIDTH-1:0];
      out_inst_o    = head.inst;
      out_imm_o     = head.imm[DATA_WIDTH-1:0];
      out_target_o  = head.target[DATA_WIDTH-1:0];
      out_rd_o      = head.inst[11:7];
      out_rs1_o     = head.inst[19:15];
      out_rs2_o     = head.inst[24:20];
      out_illegal_o = head.illegal;
    end
  end

  // Saturating back-pressure counter; a flushing cycle is not a stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (out_valid_o && !out_ready_i && !flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected entries, a
// negedge monitor pops and compares whenever the stage hands one downstream.
module tb_decode_stage;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] imm;
    logic [63:0] target;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_pc, out_imm, out_target;
  logic [31:0] out_inst;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] stall_cnt;

  logic        sat_in_ready, sat_out_valid, sat_illegal;
  logic [63:0] sat_pc, sat_imm, sat_target;
  logic [31:0] sat_inst;
  logic [4:0]  sat_rd, sat_rs1, sat_rs2;
  logic [3:0]  sat_stall;

  int   check_cnt = 0;
  int   pass_cnt  = 0;
  exp_t sb[$];

  decode_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_inst_i(in_inst), .in_pc_i(in_pc), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_pc_o(out_pc), .out_inst_o(out_inst), .out_imm_o(out_imm),
    .out_target_o(out_target), .out_rd_o(out_rd), .out_rs1_o(out_rs1), .out_rs2_o(out_rs2),
    .out_illegal_o(out_illegal), .stall_cnt_o(stall_cnt)
  );

  decode_stage #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(sat_in_ready),
    .in_inst_i(in_inst), .in_pc_i(in_pc), .flush_i(flush), .out_valid_o(sat_out_valid),
    .out_ready_i(out_ready), .out_pc_o(sat_pc), .out_inst_o(sat_inst), .out_imm_o(sat_imm),
    .out_target_o(sat_target), .out_rd_o(sat_rd), .out_rs1_o(sat_rs1), .out_rs2_o(sat_rs2),
    .out_illegal_o(sat_illegal), .stall_cnt_o(sat_stall)
  );

  always #5 clk = ~clk;

  function automatic exp_t mkExp(input logic [31:0] inst, input logic [63:0] pc,
                                 input logic [63:0] imm, input logic [63:0] target,
                                 input logic illegal);
    exp_t e;
    e.pc      = pc;
    e.inst    = inst;
    e.imm     = imm;
    e.target  = target;
    e.illegal = illegal;
    e.rd      = inst[11:7];
    e.rs1     = inst[19:15];
    e.rs2     = inst[24:20];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Offers one instruction for one clock; returns #1 after the edge.
  task automatic applyStimulus(input logic [31:0] inst, input logic [63:0] pc,
                               input logic [63:0] imm, input logic [63:0] target,
                               input logic illegal, input logic accept);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    if (accept) sb.push_back(mkExp(inst, pc, imm, target, illegal));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_cnt++;
        $display("[TB] FAIL unexpected_output: got inst 0x%0h, expected no entry", out_inst);
      end else begin
        e = sb.pop_front();
        checkOutput("mon_pc", out_pc, e.pc);
        checkOutput("mon_inst", 64'(out_inst), 64'(e.inst));
        checkOutput("mon_imm", out_imm, e.imm);
        checkOutput("mon_target", out_target, e.target);
        checkOutput("mon_illegal", 64'(out_illegal), 64'(e.illegal));
        checkOutput("mon_rd", 64'(out_rd), 64'(e.rd));
        checkOutput("mon_rs1", 64'(out_rs1), 64'(e.rs1));
        checkOutput("mon_rs2", 64'(out_rs2), 64'(e.rs2));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_stall", 64'(stall_cnt), 64'd0);
    checkOutput("rst_out_pc", out_pc, 64'd0);
    checkOutput("rst_out_imm", out_imm, 64'd0);

    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Decode patterns, streaming with execute always ready.
    applyStimulus(32'hFFF00093, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1);
    checkOutput("latency1_valid", 64'(out_valid), 64'd1);
    applyStimulus(32'hFE000EE3, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8000_000C, 1'b0, 1'b1);
    applyStimulus(32'h800002B7, 64'h8000_0020, 64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0, 1'b1);
    applyStimulus(32'h0000007F, 64'h8000_0030, 64'd0, 64'd0, 1'b1, 1'b1);
    applyStimulus(32'h00001097, 64'h8000_0040, 64'h0000_0000_0000_1000, 64'h8000_1040, 1'b0, 1'b1);
    applyStimulus(32'h008000EF, 64'h8000_0050, 64'h0000_0000_0000_0008, 64'h8000_0058, 1'b0, 1'b1);
    idle(2);
    checkOutput("drain_a_empty", 64'(sb.size()), 64'd0);

    // Back-pressure: two accepted, third refused, outputs frozen on the head.
    out_ready = 1'b0;
    applyStimulus(32'h002081B3, 64'h8000_0100, 64'd0, 64'd0, 1'b0, 1'b1);
    checkOutput("bp_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_ready_one", 64'(in_ready), 64'd1);
    checkOutput("bp_stall0", 64'(stall_cnt), 64'd0);
    applyStimulus(32'hFE512C23, 64'h8000_0104, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0, 1'b1);
    checkOutput("bp_ready_full", 64'(in_ready), 64'd0);
    checkOutput("bp_stall1", 64'(stall_cnt), 64'd1);
    checkOutput("bp_hold_inst1", 64'(out_inst), 64'h0000_0000_0020_81B3);
    applyStimulus(32'h800002B7, 64'h8000_0108, 64'd0, 64'd0, 1'b0, 1'b0);
    checkOutput("bp_ready_third", 64'(in_ready), 64'd0);
    checkOutput("bp_stall2", 64'(stall_cnt), 64'd2);
    checkOutput("bp_hold_pc", out_pc, 64'h8000_0100);
    idle(3);
    checkOutput("bp_stall5", 64'(stall_cnt), 64'd5);
    checkOutput("bp_hold_inst2", 64'(out_inst), 64'h0000_0000_0020_81B3);
    out_ready = 1'b1;
    idle(3);
    checkOutput("bp_stall_kept", 64'(stall_cnt), 64'd5);
    checkOutput("bp_drain_empty", 64'(sb.size()), 64'd0);
    checkOutput("bp_drain_valid", 64'(out_valid), 64'd0);

    // Flush while full with a same-cycle offer.
    out_ready = 1'b0;
    applyStimulus(32'hFFF00093, 64'h8000_0200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1);
    applyStimulus(32'hFE000EE3, 64'h8000_0210, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8000_020C, 1'b0, 1'b1);
    flush = 1'b1;
    sb.delete();
    applyStimulus(32'h800002B7, 64'h8000_0220, 64'd0, 64'd0, 1'b0, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ready", 64'(in_ready), 64'd1);
    checkOutput("flush_stall", 64'(stall_cnt), 64'd6);
    checkOutput("flush_pc_zero", out_pc, 64'd0);
    idle(1);
    checkOutput("flush_dropped", 64'(out_valid), 64'd0);

    // Long stall for counter saturation, then reset while full.
    applyStimulus(32'h008000EF, 64'h8000_0300, 64'h8, 64'h8000_0308, 1'b0, 1'b1);
    idle(20);
    checkOutput("stall_26", 64'(stall_cnt), 64'd26);
    checkOutput("sat_stall_f", 64'(sat_stall), 64'hF);
    applyStimulus(32'h00001097, 64'h8000_0304, 64'h1000, 64'h8000_1304, 1'b0, 1'b1);
    checkOutput("full_ready", 64'(in_ready), 64'd0);
    checkOutput("sat_stall_hold", 64'(sat_stall), 64'hF);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_ready", 64'(in_ready), 64'd1);
    checkOutput("arst_pc", out_pc, 64'd0);
    checkOutput("arst_inst", 64'(out_inst), 64'd0);
    checkOutput("arst_target", out_target, 64'd0);
    checkOutput("arst_stall", 64'(stall_cnt), 64'd0);
    checkOutput("arst_sat_stall", 64'(sat_stall), 64'd0);
    sb.delete();
    in_valid = 1'b0;

    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(32'h800002B7, 64'h8000_0400, 64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0, 1'b1);
    checkOutput("post_rst_accept", 64'(out_valid), 64'd1);
    idle(2);
    checkOutput("final_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
